// File: rtl/sa_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sa_ctrl_pkg
// Shared definitions for the systolic-array instruction sequencer:
//   - decoded instruction field widths
//   - opcode constants (LD, ST, GEMM, DRAINSYS)
//   - buffer-id codes (top, left, down)
//   - array control-state codes driven on o_ctrl_state
//   - sequencer FSM state enumeration
// ---------------------------------------------------------------------------
package sa_ctrl_pkg;

  localparam int OPCODE_W  = 4;
  localparam int BUF_ID_W  = 2;
  localparam int MEM_LOC_W = 10;

  localparam logic [OPCODE_W-1:0] OP_LD       = 4'b0010;
  localparam logic [OPCODE_W-1:0] OP_ST       = 4'b0011;
  localparam logic [OPCODE_W-1:0] OP_GEMM     = 4'b0100;
  localparam logic [OPCODE_W-1:0] OP_DRAINSYS = 4'b0101;

  localparam logic [BUF_ID_W-1:0] BUF_TOP  = 2'd0;
  localparam logic [BUF_ID_W-1:0] BUF_LEFT = 2'd1;
  localparam logic [BUF_ID_W-1:0] BUF_DOWN = 2'd2;

  localparam int CTRL_IDLE   = 0;
  localparam int CTRL_WARMUP = 1;
  localparam int CTRL_STEADY = 2;
  localparam int CTRL_DRAIN  = 3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WARMUP = 2'd1,
    S_STEADY = 2'd2,
    S_DRAIN  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/sa_phase_counter.sv
// ---------------------------------------------------------------------------
// sa_phase_counter
// Down-counter that times one sequencer phase. It is loaded with
// (phase length - 1) when a phase is entered and the phase ends in the cycle
// where the count reads zero, so a load value of N-1 yields N cycles.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset, clears the count
//   load       in   load load_value this cycle (has priority over dec)
//   load_value in   WIDTH  new count
//   dec        in   decrement by one (saturates at zero)
//   zero       out  count is zero
// ---------------------------------------------------------------------------
module sa_phase_counter #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;

  // Count register: a load always wins so a phase can be re-armed in the
  // same cycle the previous phase reaches zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/sa_inst_sequencer.sv
// ---------------------------------------------------------------------------
// sa_inst_sequencer
// Consumes decoded instructions and sequences the systolic array through its
// phases. LD/ST program the top/left/down SRAM read windows; GEMM runs a
// WARMUP phase of NUM_ROW cycles followed by a STEADY phase whose length is
// the left-window span; DRAINSYS runs a DRAIN phase of NUM_ROW+NUM_COL-1
// cycles. Illegal instructions are consumed and flagged without side effects.
//
// Ports:
//   clk, rst_n                        clock / async active-low reset
//   i_inst_valid, o_inst_ready        instruction handshake (ready in idle)
//   i_opcode, i_buf_id, i_mem_loc     decoded instruction fields
//   o_ctrl_state                      registered array phase code
//   o_{top,left,down}_sram_rd_*_addr  buffer read windows
//   o_busy                            a GEMM/DRAINSYS phase is running
//   o_done                            one-cycle pulse when a sequence ends
//   o_err                             one-cycle pulse after an illegal inst
// ---------------------------------------------------------------------------
module sa_inst_sequencer
  import sa_ctrl_pkg::*;
#(
  parameter int NUM_ROW              = 4,
  parameter int NUM_COL              = 4,
  parameter int LOG2_SRAM_BANK_DEPTH = 5,
  parameter int CTRL_WIDTH           = 4,
  parameter int OPCODE_WIDTH         = OPCODE_W,
  parameter int BUF_ID_WIDTH         = BUF_ID_W,
  parameter int MEM_LOC_WIDTH        = MEM_LOC_W
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_inst_valid,
  output logic                            o_inst_ready,
  input  logic [OPCODE_WIDTH-1:0]         i_opcode,
  input  logic [BUF_ID_WIDTH-1:0]         i_buf_id,
  input  logic [MEM_LOC_WIDTH-1:0]        i_mem_loc,
  output logic [CTRL_WIDTH-1:0]           o_ctrl_state,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_top_sram_rd_start_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_top_sram_rd_end_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_left_sram_rd_start_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_left_sram_rd_end_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_down_sram_rd_start_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_down_sram_rd_end_addr,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_err
);

  localparam int AW    = LOG2_SRAM_BANK_DEPTH;
  localparam int CNT_W = LOG2_SRAM_BANK_DEPTH + 1;

  localparam logic [CNT_W-1:0] WARMUP_LOAD = CNT_W'(NUM_ROW - 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD  = CNT_W'(NUM_ROW + NUM_COL - 2);

  seq_state_e state_q, state_d;

  logic [AW-1:0] top_start_q,  top_end_q;
  logic [AW-1:0] left_start_q, left_end_q;
  logic [AW-1:0] down_start_q, down_end_q;

  logic [AW-1:0] win_start, win_end;
  logic [AW-1:0] steady_len;

  logic             accept;
  logic             ld_top, ld_left, ld_down;
  logic             illegal;
  logic             done_d;
  logic [CTRL_WIDTH-1:0] ctrl_d;
  logic [CTRL_WIDTH-1:0] ctrl_q;
  logic             done_q, err_q;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_value;
  logic             cnt_dec;
  logic             cnt_zero;

  assign win_start = i_mem_loc[AW-1:0];
  assign win_end   = i_mem_loc[2*AW-1:AW];

  // STEADY length wraps modulo the bank depth, so end < start is legal.
  assign steady_len = left_end_q - left_start_q;

  assign accept = i_inst_valid && (state_q == S_IDLE);

  sa_phase_counter #(
    .WIDTH (CNT_W)
  ) u_phase_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .dec        (cnt_dec),
    .zero       (cnt_zero)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, instruction decode and phase-counter control. Window loads
  // and illegal detection only happen on an accepted instruction in idle.
  always_comb begin
    state_d        = state_q;
    ld_top         = 1'b0;
    ld_left        = 1'b0;
    ld_down        = 1'b0;
    illegal        = 1'b0;
    done_d         = 1'b0;
    cnt_load       = 1'b0;
    cnt_load_value = '0;
    cnt_dec        = 1'b0;
    ctrl_d         = CTRL_WIDTH'(CTRL_IDLE);

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (i_opcode)
            OP_LD: begin
              if (i_buf_id == BUF_TOP) begin
                ld_top = 1'b1;
              end else if (i_buf_id == BUF_LEFT) begin
                ld_left = 1'b1;
              end else begin
                illegal = 1'b1;
              end
            end
            OP_ST: begin
              if (i_buf_id == BUF_DOWN) begin
                ld_down = 1'b1;
              end else begin
                illegal = 1'b1;
              end
            end
            OP_GEMM: begin
              state_d        = S_WARMUP;
              cnt_load       = 1'b1;
              cnt_load_value = WARMUP_LOAD;
            end
            OP_DRAINSYS: begin
              state_d        = S_DRAIN;
              cnt_load       = 1'b1;
              cnt_load_value = DRAIN_LOAD;
            end
            default: begin
              illegal = 1'b1;
            end
          endcase
        end
      end
      S_WARMUP: begin
        if (cnt_zero) begin
          if (steady_len == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d        = S_STEADY;
            cnt_load       = 1'b1;
            cnt_load_value = CNT_W'(steady_len) - CNT_W'(1);
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_STEADY, S_DRAIN: begin
        if (cnt_zero) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    unique case (state_d)
      S_WARMUP: ctrl_d = CTRL_WIDTH'(CTRL_WARMUP);
      S_STEADY: ctrl_d = CTRL_WIDTH'(CTRL_STEADY);
      S_DRAIN:  ctrl_d = CTRL_WIDTH'(CTRL_DRAIN);
      default:  ctrl_d = CTRL_WIDTH'(CTRL_IDLE);
    endcase
  end

  // Window registers; they can only change from idle, so they stay frozen
  // for the whole of any GEMM or DRAINSYS sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_start_q  <= '0;
      top_end_q    <= '0;
      left_start_q <= '0;
      left_end_q   <= '0;
      down_start_q <= '0;
      down_end_q   <= '0;
    end else begin
      if (ld_top) begin
        top_start_q <= win_start;
        top_end_q   <= win_end;
      end
      if (ld_left) begin
        left_start_q <= win_start;
        left_end_q   <= win_end;
      end
      if (ld_down) begin
        down_start_q <= win_start;
        down_end_q   <= win_end;
      end
    end
  end

  // Registered status: the phase code follows the next state so it lines
  // up with the cycle the FSM is actually in that phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      done_q <= done_d;
      err_q  <= illegal;
    end
  end

  assign o_inst_ready = rst_n && (state_q == S_IDLE);
  assign o_busy       = (state_q != S_IDLE);
  assign o_ctrl_state = ctrl_q;
  assign o_done       = done_q;
  assign o_err        = err_q;

  assign o_top_sram_rd_start_addr  = top_start_q;
  assign o_top_sram_rd_end_addr    = top_end_q;
  assign o_left_sram_rd_start_addr = left_start_q;
  assign o_left_sram_rd_end_addr   = left_end_q;
  assign o_down_sram_rd_start_addr = down_start_q;
  assign o_down_sram_rd_end_addr   = down_end_q;

endmodule

// File: tb/tb_sa_inst_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sa_inst_sequencer
// Scoreboard bench: every accepted instruction is applied to a small
// reference model of the windows; GEMM, DRAINSYS and illegal instructions
// push an expected completion record (phase lengths plus window snapshot).
// A monitor counts the phase codes it sees and pops/compares a record on
// every o_done or o_err pulse.
// ---------------------------------------------------------------------------
module tb_sa_inst_sequencer;

  localparam int NR = 4;
  localparam int NC = 4;
  localparam int AW = 5;

  logic       clk;
  logic       rst_n;
  logic       i_inst_valid;
  logic       o_inst_ready;
  logic [3:0] i_opcode;
  logic [1:0] i_buf_id;
  logic [9:0] i_mem_loc;
  logic [3:0] o_ctrl_state;
  logic [AW-1:0] o_top_sram_rd_start_addr,  o_top_sram_rd_end_addr;
  logic [AW-1:0] o_left_sram_rd_start_addr, o_left_sram_rd_end_addr;
  logic [AW-1:0] o_down_sram_rd_start_addr, o_down_sram_rd_end_addr;
  logic       o_busy;
  logic       o_done;
  logic       o_err;

  typedef struct {
    bit         is_err;
    int         warm;
    int         steady;
    int         drain;
    logic [29:0] windows;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  logic [AW-1:0] m_ts, m_te, m_ls, m_le, m_ds, m_de;
  int cnt_warm, cnt_steady, cnt_drain;

  sa_inst_sequencer #(
    .NUM_ROW              (NR),
    .NUM_COL              (NC),
    .LOG2_SRAM_BANK_DEPTH (AW),
    .CTRL_WIDTH           (4),
    .OPCODE_WIDTH         (4),
    .BUF_ID_WIDTH         (2),
    .MEM_LOC_WIDTH        (10)
  ) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .i_inst_valid              (i_inst_valid),
    .o_inst_ready              (o_inst_ready),
    .i_opcode                  (i_opcode),
    .i_buf_id                  (i_buf_id),
    .i_mem_loc                 (i_mem_loc),
    .o_ctrl_state              (o_ctrl_state),
    .o_top_sram_rd_start_addr  (o_top_sram_rd_start_addr),
    .o_top_sram_rd_end_addr    (o_top_sram_rd_end_addr),
    .o_left_sram_rd_start_addr (o_left_sram_rd_start_addr),
    .o_left_sram_rd_end_addr   (o_left_sram_rd_end_addr),
    .o_down_sram_rd_start_addr (o_down_sram_rd_start_addr),
    .o_down_sram_rd_end_addr   (o_down_sram_rd_end_addr),
    .o_busy                    (o_busy),
    .o_done                    (o_done),
    .o_err                     (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [29:0] dutWindows();
    return {o_top_sram_rd_start_addr, o_top_sram_rd_end_addr,
            o_left_sram_rd_start_addr, o_left_sram_rd_end_addr,
            o_down_sram_rd_start_addr, o_down_sram_rd_end_addr};
  endfunction

  function automatic logic [29:0] modelWindows();
    return {m_ts, m_te, m_ls, m_le, m_ds, m_de};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pushEvent(input bit is_err, input int warm, input int steady, input int drain);
    exp_t e;
    e.is_err  = is_err;
    e.warm    = warm;
    e.steady  = steady;
    e.drain   = drain;
    e.windows = modelWindows();
    sb.push_back(e);
  endtask

  // Reference model: instruction semantics at accept time.
  task automatic modelAccept(input logic [3:0] op, input logic [1:0] b, input logic [9:0] loc);
    logic [AW-1:0] s, e, k;
    s = loc[4:0];
    e = loc[9:5];
    case (op)
      4'b0010: begin
        if (b == 2'd0) begin m_ts = s; m_te = e; end
        else if (b == 2'd1) begin m_ls = s; m_le = e; end
        else pushEvent(1'b1, 0, 0, 0);
      end
      4'b0011: begin
        if (b == 2'd2) begin m_ds = s; m_de = e; end
        else pushEvent(1'b1, 0, 0, 0);
      end
      4'b0100: begin
        k = m_le - m_ls;
        pushEvent(1'b0, NR, int'(k), 0);
      end
      4'b0101: pushEvent(1'b0, 0, 0, NR + NC - 1);
      default: pushEvent(1'b1, 0, 0, 0);
    endcase
  endtask

  // Presents one instruction (called just after a rising edge) and holds it
  // until accepted or the wait budget runs out.
  task automatic applyStimulus(input logic [3:0] op, input logic [1:0] b, input logic [9:0] loc);
    bit got;
    got          = 1'b0;
    i_opcode     = op;
    i_buf_id     = b;
    i_mem_loc    = loc;
    i_inst_valid = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (o_inst_ready) begin
        @(posedge clk);
        got = 1'b1;
      end
    end
    #1;
    i_inst_valid = 1'b0;
    if (!got) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: got no ready expected ready within 200 cycles");
    end else begin
      modelAccept(op, b, loc);
    end
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput({name, "_windows"}, {2'b0, dutWindows()}, 32'd0);
    checkOutput({name, "_status"}, {25'd0, o_ctrl_state, o_busy, o_done, o_err}, 32'd0);
  endtask

  task automatic modelReset();
    m_ts = '0; m_te = '0; m_ls = '0; m_le = '0; m_ds = '0; m_de = '0;
    sb.delete();
  endtask

  function automatic logic [9:0] loc(input int s, input int e);
    return {5'(e), 5'(s)};
  endfunction

  // Monitor: tally phase cycles, compare one record per done/err pulse.
  initial begin
    cnt_warm = 0; cnt_steady = 0; cnt_drain = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cnt_warm = 0; cnt_steady = 0; cnt_drain = 0;
      end else begin
        checkOutput("ready_vs_busy", {30'd0, o_inst_ready, o_busy},
                    {30'd0, (o_ctrl_state == 4'd0), (o_ctrl_state != 4'd0)});
        case (o_ctrl_state)
          4'd1: cnt_warm++;
          4'd2: cnt_steady++;
          4'd3: cnt_drain++;
          default: ;
        endcase
        if (o_done || o_err) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_event: got done=%0b err=%0b expected none", o_done, o_err);
          end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("event_kind", {30'd0, o_done, o_err}, {30'd0, !e.is_err, e.is_err});
            checkOutput("warmup_cycles", cnt_warm, e.warm);
            checkOutput("steady_cycles", cnt_steady, e.steady);
            checkOutput("drain_cycles", cnt_drain, e.drain);
            checkOutput("windows", {2'b0, dutWindows()}, {2'b0, e.windows});
          end
          cnt_warm = 0; cnt_steady = 0; cnt_drain = 0;
        end
      end
    end
  end

  initial begin
    int r, gap;
    rst_n        = 1'b0;
    i_inst_valid = 1'b0;
    i_opcode     = '0;
    i_buf_id     = '0;
    i_mem_loc    = '0;
    modelReset();
    #3;
    checkResetOutputs("reset_state");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("ready_after_reset", {31'd0, o_inst_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Left window 0..4, then GEMM: 4 warmup, 4 steady.
    applyStimulus(4'b0010, 2'd1, loc(0, 4));
    checkOutput("ld_left_start", {27'd0, o_left_sram_rd_start_addr}, 32'd0);
    checkOutput("ld_left_end", {27'd0, o_left_sram_rd_end_addr}, 32'd4);
    checkOutput("ld_ready", {31'd0, o_inst_ready}, 32'd1);
    applyStimulus(4'b0100, 2'd0, 10'd0);
    // Held while busy; accepted in the done cycle.
    applyStimulus(4'b0010, 2'd1, loc(7, 7));
    applyStimulus(4'b0100, 2'd3, 10'h3ff);
    applyStimulus(4'b0010, 2'd1, loc(30, 2));
    applyStimulus(4'b0100, 2'd0, 10'd0);
    applyStimulus(4'b0101, 2'd0, 10'd0);
    applyStimulus(4'b0010, 2'd0, loc(5, 17));
    applyStimulus(4'b0011, 2'd2, loc(31, 9));
    applyStimulus(4'b1111, 2'd0, loc(1, 1));
    applyStimulus(4'b0010, 2'd3, loc(2, 2));
    applyStimulus(4'b0011, 2'd0, loc(3, 3));
    applyStimulus(4'b0010, 2'd2, loc(4, 4));

    // Reset in the second STEADY cycle of a GEMM.
    applyStimulus(4'b0010, 2'd1, loc(0, 4));
    applyStimulus(4'b0100, 2'd0, 10'd0);
    repeat (5) @(posedge clk);
    #2;
    checkOutput("pre_reset_phase", {28'd0, o_ctrl_state}, 32'd2);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("mid_gemm_reset");
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(4'b0010, 2'd0, loc(3, 9));
    applyStimulus(4'b0011, 2'd1, loc(0, 0));
    applyStimulus(4'b0100, 2'd0, 10'd0);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 2)       applyStimulus(4'b0010, 2'($urandom_range(0, 3)), 10'($urandom));
      else if (r == 3)  applyStimulus(4'b0011, 2'($urandom_range(0, 3)), 10'($urandom));
      else if (r <= 5)  applyStimulus(4'b0100, 2'($urandom), 10'($urandom));
      else if (r == 6)  applyStimulus(4'b0101, 2'($urandom), 10'($urandom));
      else if (r == 7)  applyStimulus(4'($urandom), 2'($urandom), 10'($urandom));
      else              applyStimulus(4'b0010, 2'd1, 10'($urandom));
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end

    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    checkOutput("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sa_inst_sequencer.md
SA_INST_SEQUENCER -- requirements
Module: sa_inst_sequencer

Interface
REQ-001 SHALL have parameter NUM_ROW, default 4, systolic array rows.
REQ-002 SHALL have parameter NUM_COL, default 4, systolic array columns.
REQ-003 SHALL have parameter LOG2_SRAM_BANK_DEPTH, default 5, SRAM address width.
REQ-004 SHALL have parameter CTRL_WIDTH, default 4, array control-state width.
REQ-005 SHALL have parameters OPCODE_WIDTH 4, BUF_ID_WIDTH 2, MEM_LOC_WIDTH 10: decoded instruction field widths.
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 i_inst_valid  input  1  decoded instruction present.
REQ-009 o_inst_ready  output  1  sequencer accepts instruction this cycle.
REQ-010 i_opcode / i_buf_id / i_mem_loc  input  4/2/10  decoded instruction fields.
REQ-011 o_ctrl_state  output  CTRL_WIDTH  array phase: IDLE=0, WARMUP=1, STEADY=2, DRAIN=3.
REQ-012 o_top/left/down_sram_rd_start_addr, o_top/left/down_sram_rd_end_addr  output  LOG2_SRAM_BANK_DEPTH each  buffer read windows.
REQ-013 o_busy  output  1  GEMM or DRAINSYS in progress.
REQ-014 o_done  output  1  one-cycle pulse on completion of GEMM or DRAINSYS.
REQ-015 o_err  output  1  one-cycle pulse on illegal instruction.

Function
REQ-016 Accept = i_inst_valid & o_inst_ready at a rising edge; o_inst_ready SHALL be 1 only in FSM state S_IDLE.
REQ-017 Window fields: start = i_mem_loc[4:0], end = i_mem_loc[9:5].
REQ-018 LD (0010), buf_id 0 -> load top window; buf_id 1 -> load left window; registers update at accepting edge; FSM stays S_IDLE; ready stays 1.
REQ-019 ST (0011), buf_id 2 -> load down window, same timing as LD.
REQ-020 GEMM (0100): S_IDLE -> S_WARMUP for exactly NUM_ROW cycles, then S_STEADY for K = (left_end - left_start) mod 2^LOG2_SRAM_BANK_DEPTH cycles, then S_IDLE; K=0 skips S_STEADY.
REQ-021 DRAINSYS (0101): S_IDLE -> S_DRAIN for exactly NUM_ROW+NUM_COL-1 cycles, then S_IDLE.
REQ-022 o_ctrl_state SHALL be registered: equals phase code from the cycle after acceptance; 0 in S_IDLE.
REQ-023 o_busy = 1 in S_WARMUP, S_STEADY, S_DRAIN; o_done pulses in the first S_IDLE cycle after a phase sequence; a new instruction is acceptable in that same cycle.
REQ-024 Illegal: unknown opcode, LD with buf_id 2/3, ST with buf_id != 2 -> o_err pulses the cycle after acceptance; no register or FSM change.
REQ-025 Window registers SHALL hold during busy phases; instructions presented while busy are not consumed (valid held, ready 0).
REQ-026 Phase counter width LOG2_SRAM_BANK_DEPTH+1; loaded with length-1 on entry, phase exits on count 0.

Reset
REQ-027 rst_n low SHALL asynchronously force S_IDLE, counter 0, all address outputs 0, o_ctrl_state 0, o_busy/o_done/o_err 0; o_inst_ready 1 after release.
REQ-028 Reset mid-GEMM/DRAIN SHALL abort without o_done; first post-reset instruction accepted normally.

Structure
REQ-029 Package sa_ctrl_pkg SHALL hold opcode constants, ctrl-state codes (IDLE..DRAIN), buffer-id codes, field widths.
REQ-030 One sub-module sa_phase_counter (load, decrement, zero flag) SHALL implement the phase counter; FSM and window registers in top.

Verification
REQ-031 LD buf_id 1, mem_loc {end 4, start 0} -> next cycle left start 0, end 4; ready stays 1.
REQ-032 After REQ-031, GEMM -> o_ctrl_state 1 for 4 cycles, 2 for 4 cycles, 0 with o_done pulse; ready 0 throughout phases.
REQ-033 Left window start 7, end 7, GEMM -> WARMUP 4 cycles, no STEADY, o_done; left start 30, end 2 -> STEADY 4 cycles (wrap).
REQ-034 DRAINSYS -> o_ctrl_state 3 for 7 cycles (4x4), o_done, then ready 1.
REQ-035 Opcode 1111, and LD buf_id 3 -> o_err pulse each, all windows unchanged, o_ctrl_state 0.
REQ-036 rst_n low in 2nd STEADY cycle -> all outputs 0 immediately, no o_done; subsequent LD accepted.
